instr_fetch_unit: RTL and testbench

//  Fetch stage feeding the single-cycle execute core (GPR file, IR, SGPR). Holds the fetch PC and

---
 rtl/instr_fetch_unit.sv | 101 ++++++++++
 tb/tb_instr_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: walks a word-addressed instruction memory with synchronous reads and hands each
// word to execute as IR under a valid/ready handshake; honours jumps and stops for good on HALT.
module instr_fetch_unit #(
  parameter int         AW      = 8,
  parameter logic [4:0] HALT_OP = 5'd31
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          start,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_rdata,
  output logic [31:0]   ir,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          busy,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_pc;
  logic [31:0]   r_ir;
  logic          r_ir_valid;
  logic          r_halted;

  logic          w_active;
  logic          w_redirect_ok;
  logic          w_is_halt;
  logic          w_load;
  logic          w_accept;
  logic          w_halt_seen;

  assign w_active      = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ISSUE);
  assign w_redirect_ok = redirect && w_active;
  assign w_is_halt     = (imem_rdata[31:27] == HALT_OP);
  // A redirect during WAIT wins over the returning word, HALT included.
  assign w_load        = (r_state == S_WAIT) && !w_redirect_ok && !w_is_halt;
  assign w_halt_seen   = (r_state == S_WAIT) && !w_redirect_ok && w_is_halt;
  assign w_accept      = (r_state == S_ISSUE) && r_ir_valid && ir_ready;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_next = S_FETCH;
      S_FETCH:  w_state_next = S_WAIT;
      S_WAIT:   w_state_next = w_is_halt ? S_HALTED : S_ISSUE;
      S_ISSUE:  if (w_accept) w_state_next = S_FETCH;
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_redirect_ok) w_state_next = S_FETCH;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= '0;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_redirect_ok) begin
        r_fetch_pc <= redirect_pc;
        r_ir_valid <= 1'b0;
      end else begin
        if (w_load) begin
          r_ir       <= imem_rdata;
          r_pc       <= r_fetch_pc;
          r_fetch_pc <= r_fetch_pc + {{(AW-1){1'b0}}, 1'b1};
          r_ir_valid <= 1'b1;
        end
        if (w_accept) r_ir_valid <= 1'b0;
        if (w_halt_seen) r_halted <= 1'b1;
      end
    end
  end

  assign imem_en   = (r_state == S_FETCH);
  assign imem_addr = r_fetch_pc;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign busy      = w_active;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle-by-cycle vector table plus hand-written
// sequences for HALT, reset mid-flight, and address wrap on a 4-bit-address instance.
module tb_instr_fetch_unit;

  logic        clk;
  logic        sys_rst;
  logic        start;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  pc;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        busy;
  logic        halted;

  logic        start4;
  logic        imem_en4;
  logic [3:0]  imem_addr4;
  logic [31:0] imem_rdata4;
  logic [31:0] ir4;
  logic        ir_valid4;
  logic        ir_ready4;
  logic [3:0]  pc4;
  logic        redirect4;
  logic [3:0]  redirect_pc4;
  logic        busy4;
  logic        halted4;

  logic [31:0] mem  [256];
  logic [31:0] mem4 [16];

  int total = 0;
  int bad   = 0;

  instr_fetch_unit #(.AW(8), .HALT_OP(5'd31)) u_dut (
    .clk(clk), .sys_rst(sys_rst), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready), .pc(pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .busy(busy), .halted(halted)
  );

  instr_fetch_unit #(.AW(4), .HALT_OP(5'd31)) u_dut4 (
    .clk(clk), .sys_rst(sys_rst), .start(start4),
    .imem_en(imem_en4), .imem_addr(imem_addr4), .imem_rdata(imem_rdata4),
    .ir(ir4), .ir_valid(ir_valid4), .ir_ready(ir_ready4), .pc(pc4),
    .redirect(redirect4), .redirect_pc(redirect_pc4),
    .busy(busy4), .halted(halted4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memories
  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= mem[imem_addr];
    if (imem_en4) imem_rdata4 <= mem4[imem_addr4];
  end

  typedef struct {
    logic        start;
    logic        rdy;
    logic        redir;
    logic [7:0]  rpc;
    logic        en;
    logic [7:0]  addr;
    logic        valid;
    logic [31:0] ir;
    logic [7:0]  pc;
    logic        busy;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mkv(input logic s, input logic r, input logic d, input logic [7:0] rp,
                               input logic e, input logic [7:0] a, input logic v,
                               input logic [31:0] i, input logic [7:0] p, input logic b);
    vec_t t;
    t.start = s; t.rdy = r; t.redir = d; t.rpc = rp;
    t.en = e; t.addr = a; t.valid = v; t.ir = i; t.pc = p; t.busy = b;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  int        hs;
  logic [7:0] hs_pc [4];
  logic [3:0] hs_pc4 [4];
  logic [31:0] hs_ir4 [4];
  logic       saw_pc2;
  logic       done;

  initial begin
    sys_rst = 1'b1; start = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
    start4 = 1'b0; ir_ready4 = 1'b0; redirect4 = 1'b0; redirect_pc4 = 4'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'h0100_0000 | 32'(i);
    mem[0]    = 32'h1005_0004;
    mem[1]    = 32'h2000_0001;
    mem[8'h20] = 32'h0842_0000;
    mem[8'h40] = 32'h1111_2222;

    vecs[0]  = mkv(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 8'h00, 1'b0);
    vecs[1]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 32'h0000_0000, 8'h00, 1'b1);
    vecs[2]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0000_0000, 8'h00, 1'b1);
    for (int i = 3; i < 8; i++)
      vecs[i] = mkv(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 32'h1005_0004, 8'h00, 1'b1);
    vecs[8]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 32'h1005_0004, 8'h00, 1'b1);
    vecs[9]  = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 32'h1005_0004, 8'h00, 1'b1);
    vecs[10] = mkv(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 8'h01, 1'b0, 32'h1005_0004, 8'h00, 1'b1);
    vecs[11] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h20, 1'b0, 32'h1005_0004, 8'h00, 1'b1);
    vecs[12] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h20, 1'b0, 32'h1005_0004, 8'h00, 1'b1);
    vecs[13] = mkv(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 8'h21, 1'b1, 32'h0842_0000, 8'h20, 1'b1);
    vecs[14] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 32'h0842_0000, 8'h20, 1'b1);
    vecs[15] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h40, 1'b0, 32'h0842_0000, 8'h20, 1'b1);
    vecs[16] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h41, 1'b1, 32'h1111_2222, 8'h40, 1'b1);
    vecs[17] = mkv(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 32'h1111_2222, 8'h40, 1'b1);

    // Reset state
    do_reset();
    chk("rst_imem_en",  32'(imem_en),   32'h0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid),  32'h0);
    chk("rst_ir",       ir,             32'h0);
    chk("rst_pc",       32'(pc),        32'h0);
    chk("rst_busy",     32'(busy),      32'h0);
    chk("rst_halted",   32'(halted),    32'h0);

    // Table: first fetch, stall, redirect in WAIT and in ISSUE
    for (int i = 0; i < 18; i++) begin
      start = vecs[i].start; ir_ready = vecs[i].rdy;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
      chk($sformatf("c%0d_en", i),    32'(imem_en),   32'(vecs[i].en));
      chk($sformatf("c%0d_addr", i),  32'(imem_addr), 32'(vecs[i].addr));
      chk($sformatf("c%0d_valid", i), 32'(ir_valid),  32'(vecs[i].valid));
      chk($sformatf("c%0d_ir", i),    ir,             vecs[i].ir);
      chk($sformatf("c%0d_pc", i),    32'(pc),        32'(vecs[i].pc));
      chk($sformatf("c%0d_busy", i),  32'(busy),      32'(vecs[i].busy));
      step();
    end
    start = 1'b0; redirect = 1'b0; ir_ready = 1'b0;

    // HALT at address 2
    mem[0] = 32'h1005_0004;
    mem[1] = 32'h2000_0001;
    mem[2] = 32'hF800_0000;
    mem[3] = 32'h0800_0003;
    do_reset();
    start = 1'b1; step(); start = 1'b0; ir_ready = 1'b1;
    hs = 0; saw_pc2 = 1'b0; done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      if (ir_valid && pc == 8'h02) saw_pc2 = 1'b1;
      if (ir_valid && ir_ready) begin
        if (hs < 4) hs_pc[hs] = pc;
        hs++;
      end
      if (halted) done = 1'b1;
      else step();
    end
    chk("halt_reached",   32'(done),    32'h1);
    chk("halt_hs_count",  32'(hs),      32'h2);
    chk("halt_hs_pc0",    32'(hs_pc[0]), 32'h0);
    chk("halt_hs_pc1",    32'(hs_pc[1]), 32'h1);
    chk("halt_no_pc2",    32'(saw_pc2), 32'h0);
    chk("halt_busy",      32'(busy),    32'h0);
    chk("halt_ir_valid",  32'(ir_valid), 32'h0);
    start = 1'b1; redirect = 1'b1; redirect_pc = 8'h00;
    step();
    start = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("halt_hold%0d_en", c),     32'(imem_en),  32'h0);
      chk($sformatf("halt_hold%0d_halted", c), 32'(halted),   32'h1);
      chk($sformatf("halt_hold%0d_valid", c),  32'(ir_valid), 32'h0);
      chk($sformatf("halt_hold%0d_busy", c),   32'(busy),     32'h0);
      step();
    end

    // Reset mid-flight; redirect ignored in IDLE
    ir_ready = 1'b0;
    mem[8'h30] = 32'h0C00_0030;
    do_reset();
    redirect = 1'b1; redirect_pc = 8'h55; step(); redirect = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("idle_redir_ignored_addr", 32'(imem_addr), 32'h0);
    chk("idle_redir_fetch_en",     32'(imem_en),   32'h1);
    redirect = 1'b1; redirect_pc = 8'h30; step(); redirect = 1'b0;
    chk("fetch_redir_addr", 32'(imem_addr), 32'h30);
    step(); step();
    chk("pre_rst_valid", 32'(ir_valid), 32'h1);
    chk("pre_rst_pc",    32'(pc),       32'h30);
    chk("pre_rst_ir",    ir,            32'h0C00_0030);
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    chk("rst_issue_valid", 32'(ir_valid),  32'h0);
    chk("rst_issue_busy",  32'(busy),      32'h0);
    chk("rst_issue_en",    32'(imem_en),   32'h0);
    chk("rst_issue_addr",  32'(imem_addr), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("rst_issue_refetch_en",   32'(imem_en),   32'h1);
    chk("rst_issue_refetch_addr", 32'(imem_addr), 32'h0);
    step();
    sys_rst = 1'b1; step(); sys_rst = 1'b0;
    chk("rst_wait_valid", 32'(ir_valid),  32'h0);
    chk("rst_wait_busy",  32'(busy),      32'h0);
    chk("rst_wait_en",    32'(imem_en),   32'h0);
    chk("rst_wait_addr",  32'(imem_addr), 32'h0);
    start = 1'b1; step(); start = 1'b0;
    chk("rst_wait_refetch_addr", 32'(imem_addr), 32'h0);
    step(); step();
    chk("rst_wait_refetch_valid", 32'(ir_valid), 32'h1);
    chk("rst_wait_refetch_pc",    32'(pc),       32'h0);
    chk("rst_wait_refetch_ir",    ir,            32'h1005_0004);

    // AW=4 wrap: jump to 14, then issue 14, 15, 0, 1
    do_reset();
    start4 = 1'b1; step(); start4 = 1'b0;
    redirect4 = 1'b1; redirect_pc4 = 4'd14; step(); redirect4 = 1'b0;
    ir_ready4 = 1'b1;
    hs = 0;
    for (int c = 0; c < 40 && hs < 4; c++) begin
      if (ir_valid4 && ir_ready4) begin
        hs_pc4[hs] = pc4;
        hs_ir4[hs] = ir4;
        hs++;
      end
      step();
    end
    ir_ready4 = 1'b0;
    chk("wrap_hs_count", 32'(hs), 32'h4);
    chk("wrap_pc0", 32'(hs_pc4[0]), 32'd14);
    chk("wrap_pc1", 32'(hs_pc4[1]), 32'd15);
    chk("wrap_pc2", 32'(hs_pc4[2]), 32'd0);
    chk("wrap_pc3", 32'(hs_pc4[3]), 32'd1);
    chk("wrap_ir0", hs_ir4[0], 32'h0100_000E);
    chk("wrap_ir1", hs_ir4[1], 32'h0100_000F);
    chk("wrap_ir2", hs_ir4[2], 32'h0100_0000);
    chk("wrap_ir3", hs_ir4[3], 32'h0100_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
